// File: rtl/pe_row_acc_if.sv
// Bus bundle for pe_row_acc: weight load, data beats in, forwarded beats and frame results out.
interface pe_row_acc_if #(
  parameter int unsigned CH = 8,
  parameter int unsigned DW = 7,
  parameter int unsigned WW = 2,
  parameter int unsigned OW = 8
);
  logic             clr;
  logic             w_load;
  logic [CH*WW-1:0] w_bus;
  logic             in_valid;
  logic             in_last;
  logic [CH*DW-1:0] in_data;
  logic [CH*DW-1:0] fwd_data;
  logic             fwd_valid;
  logic [OW-1:0]    result;
  logic             out_valid;

  modport master (
    output clr, w_load, w_bus, in_valid, in_last, in_data,
    input  fwd_data, fwd_valid, result, out_valid
  );

  modport slave (
    input  clr, w_load, w_bus, in_valid, in_last, in_data,
    output fwd_data, fwd_valid, result, out_valid
  );
endinterface

// File: rtl/pe_row_acc.sv
// One row of CH multiply PEs feeding a pipelined adder tree and a saturating frame accumulator.
// Beats are registered once (also the forward path), multiplied, reduced over log2(CH) levels, then accumulated.
module pe_row_acc #(
  parameter int unsigned CH       = 8,
  parameter int unsigned DW       = 7,
  parameter int unsigned WW       = 2,
  parameter int unsigned OW       = 8,
  parameter int unsigned MAX_TAPS = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  pe_row_acc_if.slave   bus
);
  localparam int unsigned K    = $clog2(CH);
  localparam int unsigned PW   = DW + WW;
  localparam int unsigned TW   = PW + K;
  localparam int unsigned ACCW = TW + $clog2(MAX_TAPS);
  localparam int unsigned NS   = K + 2;

  localparam logic signed [ACCW-1:0] SAT_HI = {{(ACCW-OW+1){1'b0}}, {(OW-1){1'b1}}};
  localparam logic signed [ACCW-1:0] SAT_LO = {{(ACCW-OW+1){1'b1}}, {(OW-1){1'b0}}};

  logic [CH*WW-1:0]       w_q;
  logic [CH*WW-1:0]       wsnap_q;
  logic [CH*DW-1:0]       fwd_data_q;
  logic                   fwd_valid_q;
  logic [NS-1:0]          tv_q;
  logic [NS-1:0]          tl_q;
  logic signed [PW-1:0]   prod_q [CH];
  logic signed [TW-1:0]   tree_q [1:CH-1];
  logic signed [TW-1:0]   node   [1:2*CH-1];
  logic signed [ACCW-1:0] acc_q;
  logic signed [ACCW-1:0] acc_d;
  logic signed [ACCW-1:0] sum_c;
  logic [OW-1:0]          result_q;
  logic [OW-1:0]          result_d;
  logic                   out_valid_q;
  logic                   out_valid_d;

  // Input stage; wsnap_q keeps the weights in force when the beat was accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_q         <= '0;
      wsnap_q     <= '0;
      fwd_data_q  <= '0;
      fwd_valid_q <= 1'b0;
      tv_q        <= '0;
      tl_q        <= '0;
    end else begin
      if (bus.w_load) w_q <= bus.w_bus;
      wsnap_q     <= w_q;
      fwd_data_q  <= bus.in_data;
      fwd_valid_q <= bus.in_valid;
      if (bus.clr) begin
        tv_q <= '0;
        tl_q <= '0;
      end else begin
        tv_q <= {tv_q[NS-2:0], bus.in_valid};
        tl_q <= {tl_q[NS-2:0], bus.in_valid & bus.in_last};
      end
    end
  end

  // Product stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(CH); i++) prod_q[i] <= '0;
    end else begin
      for (int i = 0; i < int'(CH); i++)
        prod_q[i] <= PW'($signed(fwd_data_q[i*DW +: DW])) * PW'($signed(wsnap_q[i*WW +: WW]));
    end
  end

  // Heap-ordered tree: node n sums children 2n and 2n+1; leaves CH..2CH-1 are the products.
  always_comb begin
    for (int n = 1; n < int'(CH); n++) node[n] = tree_q[n];
    for (int i = 0; i < int'(CH); i++) node[int'(CH)+i] = TW'(prod_q[i]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int n = 1; n < int'(CH); n++) tree_q[n] <= '0;
    end else begin
      for (int n = 1; n < int'(CH); n++) tree_q[n] <= node[2*n] + node[2*n+1];
    end
  end

  assign sum_c = acc_q + ACCW'(node[1]);

  // Accumulate / close frame with saturation; clr wins over a closing beat.
  always_comb begin
    acc_d       = acc_q;
    result_d    = result_q;
    out_valid_d = 1'b0;
    if (bus.clr) begin
      acc_d = '0;
    end else if (tv_q[NS-1]) begin
      if (tl_q[NS-1]) begin
        acc_d       = '0;
        out_valid_d = 1'b1;
        if (sum_c > SAT_HI)      result_d = SAT_HI[OW-1:0];
        else if (sum_c < SAT_LO) result_d = SAT_LO[OW-1:0];
        else                     result_d = sum_c[OW-1:0];
      end else begin
        acc_d = sum_c;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q       <= '0;
      result_q    <= '0;
      out_valid_q <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      result_q    <= result_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.fwd_data  = fwd_data_q;
  assign bus.fwd_valid = fwd_valid_q;
  assign bus.result    = result_q;
  assign bus.out_valid = out_valid_q;
endmodule

// File: tb/tb_pe_row_acc.sv
// Directed and random bench for pe_row_acc against a frame-level dot-product model.
module tb_pe_row_acc;
  localparam int unsigned CH = 8, DW = 7, WW = 2, OW = 8, MAX_TAPS = 16;
  localparam int LAT = 5;

  typedef struct { int val; int due; } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  pe_row_acc_if #(.CH(CH), .DW(DW), .WW(WW), .OW(OW)) bus ();
  pe_row_acc #(.CH(CH), .DW(DW), .WW(WW), .OW(OW), .MAX_TAPS(MAX_TAPS)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  int               mw [CH];
  int               frame_sum;
  exp_t             pend [$];
  logic [OW-1:0]    exp_res;
  logic [CH*DW-1:0] exp_fd;
  logic             exp_fv;
  logic             exp_ov;
  int               cyc;
  int               errors = 0;
  int               checks = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d: observed %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic check_outputs();
    chk("fwd_data",  64'(bus.fwd_data),  64'(exp_fd));
    chk("fwd_valid", 64'(bus.fwd_valid), 64'(exp_fv));
    chk("out_valid", 64'(bus.out_valid), 64'(exp_ov));
    chk("result",    64'(bus.result),    64'(exp_res));
  endtask

  function automatic int sat(input int s);
    int hi = (1 << (OW-1)) - 1;
    int lo = -(1 << (OW-1));
    if (s > hi) return hi;
    if (s < lo) return lo;
    return s;
  endfunction

  function automatic logic [CH*DW-1:0] fill_d(input int x);
    logic [CH*DW-1:0] v;
    for (int i = 0; i < int'(CH); i++) v[i*DW +: DW] = DW'(x);
    return v;
  endfunction

  function automatic logic [CH*WW-1:0] fill_w(input int x, input bit alt);
    logic [CH*WW-1:0] v;
    for (int i = 0; i < int'(CH); i++) v[i*WW +: WW] = (alt && (i % 2 == 1)) ? WW'(-x) : WW'(x);
    return v;
  endfunction

  // One clock: drive, let the edge happen, advance the model, sample 1 time unit later.
  task automatic step(input logic v, input logic l, input logic [CH*DW-1:0] d,
                      input logic wl, input logic [CH*WW-1:0] wb, input logic c);
    int dot;
    bus.in_valid = v; bus.in_last = l; bus.in_data = d;
    bus.w_load = wl;  bus.w_bus = wb;  bus.clr = c;
    @(posedge clk);
    cyc++;
    exp_fd = d;
    exp_fv = v;
    if (c) begin
      frame_sum = 0;
      pend.delete();
    end else if (v) begin
      dot = 0;
      for (int i = 0; i < int'(CH); i++) dot += int'($signed(d[i*DW +: DW])) * mw[i];
      frame_sum += dot;
      if (l) begin
        pend.push_back('{val: sat(frame_sum), due: cyc + LAT});
        frame_sum = 0;
      end
    end
    if (wl) for (int i = 0; i < int'(CH); i++) mw[i] = int'($signed(wb[i*WW +: WW]));
    exp_ov = 1'b0;
    if (pend.size() > 0 && pend[0].due == cyc) begin
      exp_ov  = 1'b1;
      exp_res = OW'(pend[0].val);
      void'(pend.pop_front());
    end
    #1;
    check_outputs();
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
  endtask

  task automatic load_w(input logic [CH*WW-1:0] wb);
    step(1'b0, 1'b0, '0, 1'b1, wb, 1'b0);
  endtask

  task automatic do_reset();
    bus.in_valid = 1'b0; bus.in_last = 1'b0; bus.in_data = '0;
    bus.w_load = 1'b0;   bus.w_bus = '0;     bus.clr = 1'b0;
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < int'(CH); i++) mw[i] = 0;
    frame_sum = 0;
    pend.delete();
    exp_res = '0; exp_fd = '0; exp_fv = 1'b0; exp_ov = 1'b0;
    check_outputs();
    @(posedge clk);
    cyc++;
    #1;
    check_outputs();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic             v, l, c, wl;
    logic [CH*DW-1:0] d;
    logic [CH*WW-1:0] wb;
    int               fb;
    cyc = 0;
    rst_n = 1'b1;
    bus.in_valid = 1'b0; bus.in_last = 1'b0; bus.in_data = '0;
    bus.w_load = 1'b0;   bus.w_bus = '0;     bus.clr = 1'b0;
    #2;
    do_reset();
    idle(2);

    // Single beat, all +1 weights, data 3 -> 24 five cycles later.
    load_w(fill_w(1, 1'b0));
    step(1'b1, 1'b1, fill_d(3), 1'b0, '0, 1'b0);
    idle(7);

    // Alternating weights, three beats with a bubble -> 0.
    load_w(fill_w(1, 1'b1));
    step(1'b1, 1'b0, fill_d(10), 1'b0, '0, 1'b0);
    step(1'b1, 1'b0, fill_d(10), 1'b0, '0, 1'b0);
    step(1'b0, 1'b1, fill_d(55), 1'b0, '0, 1'b0);
    step(1'b1, 1'b1, fill_d(10), 1'b0, '0, 1'b0);
    idle(7);

    // Positive saturation, then back-to-back negative saturation frame.
    load_w(fill_w(1, 1'b0));
    repeat (3) step(1'b1, 1'b0, fill_d(63), 1'b0, '0, 1'b0);
    step(1'b1, 1'b1, fill_d(63), 1'b0, '0, 1'b0);
    step(1'b1, 1'b1, fill_d(-64), 1'b0, '0, 1'b0);
    idle(7);

    // Weight load coincident with the first beat still uses old weights.
    step(1'b1, 1'b0, fill_d(1), 1'b1, fill_w(-1, 1'b0), 1'b0);
    step(1'b1, 1'b1, fill_d(1), 1'b0, '0, 1'b0);
    idle(7);

    // clr mid-frame (with a concurrent beat) drops the frame.
    load_w(fill_w(1, 1'b0));
    step(1'b1, 1'b0, fill_d(2), 1'b0, '0, 1'b0);
    step(1'b1, 1'b0, fill_d(2), 1'b0, '0, 1'b0);
    step(1'b1, 1'b1, fill_d(2), 1'b0, '0, 1'b1);
    idle(7);
    step(1'b1, 1'b1, fill_d(2), 1'b0, '0, 1'b0);
    idle(7);

    // Reset mid-frame drops the frame and the weights.
    step(1'b1, 1'b0, fill_d(2), 1'b0, '0, 1'b0);
    step(1'b1, 1'b0, fill_d(2), 1'b0, '0, 1'b0);
    do_reset();
    idle(6);
    load_w(fill_w(1, 1'b0));
    step(1'b1, 1'b1, fill_d(2), 1'b0, '0, 1'b0);
    idle(7);

    // Random traffic with occasional weight loads and clr; frames capped at 8 beats.
    fb = 0;
    for (int n = 0; n < 400; n++) begin
      v  = ($urandom_range(0, 3) != 0);
      c  = ($urandom_range(0, 39) == 0);
      wl = ($urandom_range(0, 15) == 0);
      l  = v ? (($urandom_range(0, 3) == 0) || fb == 7) : 1'($urandom_range(0, 1));
      for (int i = 0; i < int'(CH); i++) begin
        case ($urandom_range(0, 5))
          0:       d[i*DW +: DW] = DW'(63);
          1:       d[i*DW +: DW] = DW'(-64);
          default: d[i*DW +: DW] = DW'($urandom);
        endcase
      end
      wb = (CH*WW)'($urandom);
      step(v, l, d, wl, wb, c);
      if (c) fb = 0;
      else if (v) fb = l ? 0 : fb + 1;
    end
    idle(8);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/pe_row_acc.md
PE_ROW_ACC -- requirements
Module: pe_row_acc

Interface
REQ-001 Parameter CH, default 8: number of input channels / PEs in the row; power of two, 2..32.
REQ-002 Parameter DW, default 7: signed input data width.
REQ-003 Parameter WW, default 2: signed weight width.
REQ-004 Parameter OW, default 8: signed saturated result width.
REQ-005 Parameter MAX_TAPS, default 16: maximum beats per accumulation frame.
REQ-006 Port clk, input, 1: clock, all logic rising-edge.
REQ-007 Port rst_n, input, 1: reset, asynchronous, active-low.
REQ-008 Port clr, input, 1: synchronous flush of pipeline valids and accumulator.
REQ-009 Port w_load, input, 1: latch w_bus into the weight registers this cycle.
REQ-010 Port w_bus, input, CH*WW: packed signed weights, channel i at bits [i*WW +: WW].
REQ-011 Port in_valid, input, 1: data beat present on in_data.
REQ-012 Port in_last, input, 1: qualifies in_valid; final beat of the frame.
REQ-013 Port in_data, input, CH*DW: packed signed data, channel i at bits [i*DW +: DW].
REQ-014 Port fwd_data, output, CH*DW: in_data registered one cycle, for the next row.
REQ-015 Port fwd_valid, output, 1: in_valid registered one cycle (next-row enable).
REQ-016 Port result, output, OW: signed saturated frame sum.
REQ-017 Port out_valid, output, 1: one-cycle pulse, result valid.

Function
REQ-018 Weight registers update only on w_load; a beat accepted in the same cycle as w_load uses the old weights.
REQ-019 Stage P (1 cycle): registered full-width products data_i*w_i, DW+WW bits signed, with valid and last tags.
REQ-020 Stages T1..Tk, k=log2(CH): registered binary adder tree; each level widens by 1 bit; valid and last tags travel with the data.
REQ-021 Accumulator ACCW = DW+WW+log2(CH)+log2(MAX_TAPS) bits signed; adds tree output when the tree-output valid is high.
REQ-022 Tree-output valid with last: result <= sat(acc + tree_sum), out_valid <= 1, acc <= 0, all in the same cycle.
REQ-023 Latency: out_valid rises exactly k+2 cycles after the clock edge that accepts the in_last beat.
REQ-024 Saturation: value > 2^(OW-1)-1 gives 2^(OW-1)-1; value < -2^(OW-1) gives -2^(OW-1); otherwise exact.
REQ-025 Bubbles (in_valid low) inside a frame are permitted and do not alter acc.
REQ-026 Back-to-back frames: a beat following in_last on the next cycle starts a fresh frame with no lost or merged beats.
REQ-027 Ignore in_last when in_valid is low.
REQ-028 clr: all pipeline valid/last tags and acc go to 0 next cycle; an in-flight frame produces no out_valid; clr overrides a simultaneous in_valid.
REQ-029 result holds its last value while out_valid is low.
REQ-030 fwd_data/fwd_valid are unaffected by clr; they always follow in_data/in_valid with one-cycle delay.
REQ-031 Frames longer than MAX_TAPS: unsupported; result is undefined, but no lock-up.

Reset
REQ-032 rst_n low: weights, products, tree, acc, result, fwd_data = 0; out_valid, fwd_valid and all tags = 0, immediately and asynchronously.
REQ-033 Reset mid-frame discards the frame; the first frame after release starts from acc = 0.

Verification (CH=8, DW=7, WW=2, OW=8, k=3)
REQ-034 All weights +1, one beat of all data = 3 with last -> result = 24, out_valid exactly 5 cycles after the beat.
REQ-035 Weights alternating +1/-1, 3 beats of data = 10 with a bubble between beats 2 and 3 -> result = 0, single out_valid pulse.
REQ-036 Weights +1, 4 beats of data = 63 -> sum 2016 -> result = 127; weights +1, one beat of data = -64 -> result = -128.
REQ-037 w_load to all -1 on the same cycle as beat 1 (data = 1, old weights +1), beat 2 data = 1 with last -> result = 8 - 8 = 0.
REQ-038 rst_n pulse or clr between beats 2 and 3 of a frame -> no out_valid for that frame; next single-beat frame with data = 2, weights +1 -> result = 16.
REQ-039 Random in_valid/in_data -> fwd_data and fwd_valid equal inputs delayed by exactly 1 cycle, including across clr.
